// File: rtl/control_multiciclo_if.sv
// Control bundle between the multicycle control FSM and the MIPS-subset datapath.
// The control unit is the master: it reads Opcode/MemListo and drives the strobes and selectors.
interface control_multiciclo_if;
  logic [5:0] Opcode;
  logic       MemListo;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       Signo;
  logic       Error;
  logic [3:0] Estado;

  modport master (
    input  Opcode, MemListo,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Signo, Error, Estado
  );

  modport slave (
    output Opcode, MemListo,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Signo, Error, Estado
  );
endinterface

// File: rtl/control_multiciclo.sv
// Multicycle control FSM for the 32-bit MIPS-subset datapath, with a bounded
// wait on the variable-latency memory and a sticky timeout flag.
module control_multiciclo #(
  parameter int MAX_ESPERA = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  control_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    EXEC_I    = 4'd10,
    I_WB      = 4'd11,
    ILEGAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [7:0] LIMIT = 8'(MAX_ESPERA - 1);

  state_t     state;
  state_t     done_state;
  logic [7:0] cnt;
  logic       error;
  logic       signo;
  logic       is_store;

  logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsource;

  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_R:                              return EXEC_R;
      OP_LW, OP_SW:                      return MEM_ADDR;
      OP_BEQ:                            return BRANCH;
      OP_J:                              return JUMP;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: return EXEC_I;
      default:                           return ILEGAL;
    endcase
  endfunction

  // Destination of each memory-wait state once MemListo arrives.
  always_comb begin
    done_state = FETCH;
    case (state)
      FETCH:    done_state = DECODE;
      MEM_READ: done_state = MEM_WB;
      default:  done_state = FETCH;
    endcase
  end

  // NOTE: all state updates use <= so every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      cnt      <= '0;
      error    <= 1'b0;
      signo    <= 1'b1;
      is_store <= 1'b0;
    end else begin
      cnt <= '0;
      case (state)
        FETCH, MEM_READ, MEM_WRITE: begin
          if (bus.MemListo) begin
            state <= done_state;
          end else if (cnt == LIMIT) begin
            error <= 1'b1;
            state <= FETCH;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DECODE: begin
          signo    <= !(bus.Opcode == OP_ANDI || bus.Opcode == OP_ORI);
          // Remember lw/sw here so MEM_ADDR does not need to look at Opcode again.
          is_store <= (bus.Opcode == OP_SW);
          state    <= decode_next(bus.Opcode);
        end
        MEM_ADDR: state <= is_store ? MEM_WRITE : MEM_READ;
        MEM_WB:   state <= FETCH;
        EXEC_R:   state <= R_WB;
        R_WB:     state <= FETCH;
        BRANCH:   state <= FETCH;
        JUMP:     state <= FETCH;
        EXEC_I:   state <= I_WB;
        I_WB:     state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    case (state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = bus.MemListo;
        pcwrite = bus.MemListo;
      end
      DECODE:   alusrcb = 2'b11;
      MEM_ADDR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEM_READ: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEM_WB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEM_WRITE: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      EXEC_R: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      R_WB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      EXEC_I: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = (bus.Opcode == OP_ADDI) ? 2'b00 : 2'b11;
      end
      I_WB:    regwrite = 1'b1;
      default: ;
    endcase
  end

  // Write strobes are masked by rst_n so none can pulse while reset is held.
  assign bus.PCWrite     = pcwrite     & rst_n;
  assign bus.PCWriteCond = pcwritecond & rst_n;
  assign bus.MemWrite    = memwrite    & rst_n;
  assign bus.IRWrite     = irwrite     & rst_n;
  assign bus.RegWrite    = regwrite    & rst_n;
  assign bus.IorD        = iord;
  assign bus.MemRead     = memread;
  assign bus.RegDst      = regdst;
  assign bus.MemtoReg    = memtoreg;
  assign bus.ALUSrcA     = alusrca;
  assign bus.ALUSrcB     = alusrcb;
  assign bus.ALUOp       = aluop;
  assign bus.PCSource    = pcsource;
  assign bus.Signo       = signo;
  assign bus.Error       = error;
  assign bus.Estado      = state;

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench for control_multiciclo: stimulus queues the expected per-cycle
// response, a negedge monitor pops and compares it against the DUT.
module tb_control_multiciclo;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  typedef struct {
    string      tag;
    logic [3:0] st;
    ctrl_t      c;
    logic       er;
    logic       sg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_multiciclo_if bus();

  control_multiciclo #(.MAX_ESPERA(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Control word each state must present, written straight from the state table.
  function automatic ctrl_t ref_ctrl(input int st, input logic ml, input logic [5:0] op,
                                     input logic rst);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = ml; c.pcwrite = ml; end
      1:  c.alusrcb = 2'b11;
      2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      3:  begin c.memread = 1; c.iord = 1; end
      4:  begin c.regwrite = 1; c.memtoreg = 1; end
      5:  begin c.memwrite = 1; c.iord = 1; end
      6:  begin c.alusrca = 1; c.aluop = 2'b10; end
      7:  begin c.regwrite = 1; c.regdst = 1; end
      8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcwritecond = 1; c.pcsource = 2'b01; end
      9:  begin c.pcwrite = 1; c.pcsource = 2'b10; end
      10: begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = (op == 6'b001000) ? 2'b00 : 2'b11; end
      11: c.regwrite = 1;
      default: ;
    endcase
    if (!rst) begin
      c.pcwrite = 0; c.pcwritecond = 0; c.memwrite = 0; c.irwrite = 0; c.regwrite = 0;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s: got %b expected %b", name, got, want);
    else
      n_pass++;
  endtask

  // One clock of stimulus: drive inputs, queue what the DUT must show this cycle.
  task automatic cyc(input string tag, input logic ml, input logic [5:0] op, input int st,
                     input logic er, input logic sg);
    exp_t e;
    bus.MemListo = ml;
    bus.Opcode   = op;
    e.tag = tag; e.st = 4'(st); e.c = ref_ctrl(st, ml, op, rst_n); e.er = er; e.sg = sg;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    rst_n = 1'b0;
    e.tag = tag; e.st = 4'd0; e.c = ref_ctrl(0, bus.MemListo, bus.Opcode, 1'b0);
    e.er = 1'b0; e.sg = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents a full control word.
  initial begin
    exp_t  e;
    ctrl_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
               bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
               bus.PCSource};
        check({e.tag, " estado"}, 16'(bus.Estado), 16'(e.st));
        check({e.tag, " ctrl"},   16'(got),        16'(e.c));
        check({e.tag, " error"},  16'(bus.Error),  16'(e.er));
        check({e.tag, " signo"},  16'(bus.Signo),  16'(e.sg));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.MemListo = 1'b1;
    bus.Opcode   = 6'b000000;
    @(posedge clk);
    #1;
    do_reset("reset");

    // Two back-to-back R-type instructions, zero-wait memory.
    for (int k = 0; k < 2; k++) begin
      cyc("rtype", 1, 6'b000000, 0, 0, 1);
      cyc("rtype", 1, 6'b000000, 1, 0, 1);
      cyc("rtype", 1, 6'b000000, 6, 0, 1);
      cyc("rtype", 1, 6'b000000, 7, 0, 1);
    end

    // lw with three wait cycles in MEM_READ; MemListo high in non-memory states is ignored.
    cyc("lw", 1, 6'b100011, 0, 0, 1);
    cyc("lw", 1, 6'b100011, 1, 0, 1);
    cyc("lw", 1, 6'b100011, 2, 0, 1);
    cyc("lw", 0, 6'b100011, 3, 0, 1);
    cyc("lw", 0, 6'b100011, 3, 0, 1);
    cyc("lw", 0, 6'b100011, 3, 0, 1);
    cyc("lw", 1, 6'b100011, 3, 0, 1);
    cyc("lw", 1, 6'b100011, 4, 0, 1);

    // MemListo arriving exactly at the wait limit wins over the timeout.
    for (int k = 0; k < 14; k++) cyc("tie", 0, 6'b000000, 0, 0, 1);
    cyc("tie", 1, 6'b000000, 0, 0, 1);
    cyc("tie", 1, 6'b000000, 1, 0, 1);
    cyc("tie", 1, 6'b000000, 6, 0, 1);
    cyc("tie", 1, 6'b000000, 7, 0, 1);

    // Immediate instructions: Signo follows the last decoded opcode.
    cyc("ori",  1, 6'b001101, 0,  0, 1);
    cyc("ori",  1, 6'b001101, 1,  0, 1);
    cyc("ori",  1, 6'b001101, 10, 0, 0);
    cyc("ori",  1, 6'b001101, 11, 0, 0);
    cyc("addi", 1, 6'b001000, 0,  0, 0);
    cyc("addi", 1, 6'b001000, 1,  0, 0);
    cyc("addi", 1, 6'b001000, 10, 0, 1);
    cyc("addi", 1, 6'b001000, 11, 0, 1);
    cyc("andi", 1, 6'b001100, 0,  0, 1);
    cyc("andi", 1, 6'b001100, 1,  0, 1);
    cyc("andi", 1, 6'b001100, 10, 0, 0);
    cyc("andi", 1, 6'b001100, 11, 0, 0);
    cyc("slti", 1, 6'b001010, 0,  0, 0);
    cyc("slti", 1, 6'b001010, 1,  0, 0);
    cyc("slti", 1, 6'b001010, 10, 0, 1);
    cyc("slti", 1, 6'b001010, 11, 0, 1);

    // Fetch timeout: Error rises after 15 idle cycles, stays set, fetch then proceeds.
    for (int k = 0; k < 15; k++) cyc("timeout", 0, 6'b000000, 0, 0, 1);
    for (int k = 0; k < 3; k++)  cyc("timeout", 0, 6'b000000, 0, 1, 1);
    cyc("timeout", 1, 6'b000000, 0, 1, 1);
    cyc("timeout", 1, 6'b000000, 1, 1, 1);
    cyc("timeout", 1, 6'b000000, 6, 1, 1);
    cyc("timeout", 1, 6'b000000, 7, 1, 1);

    cyc("illegal", 1, 6'b111111, 0,  1, 1);
    cyc("illegal", 1, 6'b111111, 1,  1, 1);
    cyc("illegal", 1, 6'b111111, 12, 1, 1);
    cyc("jump",    1, 6'b000010, 0,  1, 1);
    cyc("jump",    1, 6'b000010, 1,  1, 1);
    cyc("jump",    1, 6'b000010, 9,  1, 1);
    cyc("beq",     1, 6'b000100, 0,  1, 1);
    cyc("beq",     1, 6'b000100, 1,  1, 1);
    cyc("beq",     1, 6'b000100, 8,  1, 1);
    cyc("sw",      1, 6'b101011, 0,  1, 1);
    cyc("sw",      1, 6'b101011, 1,  1, 1);
    cyc("sw",      1, 6'b101011, 2,  1, 1);
    cyc("sw",      1, 6'b101011, 5,  1, 1);

    // sw stalled in MEM_WRITE, then reset asserted mid-cycle.
    cyc("sw_rst", 1, 6'b101011, 0, 1, 1);
    cyc("sw_rst", 1, 6'b101011, 1, 1, 1);
    cyc("sw_rst", 1, 6'b101011, 2, 1, 1);
    cyc("sw_rst", 0, 6'b101011, 5, 1, 1);
    cyc("sw_rst", 0, 6'b101011, 5, 1, 1);
    do_reset("mid_reset");
    cyc("post_rst", 1, 6'b000000, 0, 0, 1);
    cyc("post_rst", 1, 6'b000000, 1, 0, 1);
    cyc("post_rst", 1, 6'b000000, 6, 0, 1);
    cyc("post_rst", 1, 6'b000000, 7, 0, 1);

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Multicycle control FSM for the 32-bit MIPS-subset datapath.
- Decodes the opcode held in the instruction register and sequences PC, memory, IR, register file, ALU and the 16→32 immediate extender.
- Selects signed or unsigned extension through Signo.
- Handshakes with a variable-latency memory via MemListo, with a bounded-wait timeout.

Parameters:
- MAX_ESPERA, 15: maximum cycles spent in any memory state waiting for MemListo before timeout (1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- Opcode  input  6  IR[31:26], stable from DECODE onward
- MemListo  input  1  memory access complete this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero
- IorD  output  1  0 = PC address, 1 = ALUOut address
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  IR load
- RegDst  output  1  1 = rd, 0 = rt
- MemtoReg  output  1  1 = MDR, 0 = ALUOut to register file
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = reg A
- ALUSrcB  output  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct, 11 = opcode-immediate
- PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- Signo  output  1  extender mode, 1 = signed, 0 = zero-extend
- Error  output  1  sticky memory-timeout flag
- Estado  output  4  current state code, for debug

Behaviour:
- Reset (async, rst_n=0):
  - State = FETCH(0); wait counter = 0; Error = 0; Signo = 1.
  - All control outputs except the state-decoded FETCH signals are 0.
- Control outputs are Moore, decoded combinationally from state (and MemListo where noted).
- Signo is a register.
- State codes:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - EXEC_R = 6, R_WB = 7, BRANCH = 8, JUMP = 9, EXEC_I = 10, I_WB = 11, ILEGAL = 12
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the cycle MemListo=1; that cycle → DECODE. Otherwise stay.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Signo <= 0 for andi(001100) and ori(001101); otherwise 1.
  - Next state by opcode:
    - 000000 → EXEC_R
    - lw 100011 / sw 101011 → MEM_ADDR
    - beq 000100 → BRANCH
    - j 000010 → JUMP
    - addi 001000, slti 001010, andi, ori → EXEC_I
    - anything else → ILEGAL
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Wait for MemListo → MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Wait for MemListo → FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10; ALUOp=00 for addi, 11 otherwise → I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0 → FETCH.
- ILEGAL: all controls 0, one cycle → FETCH; the PC is not advanced beyond the fetch increment.
- Wait counter:
  - Cleared on entry to every state.
  - Increments each cycle in FETCH, MEM_READ or MEM_WRITE while MemListo=0.
  - When counter == MAX_ESPERA-1 and MemListo=0: Error <= 1, next state FETCH.
  - On a FETCH timeout, no IRWrite/PCWrite; re-fetch restarts from count 0.
  - MemListo in the same cycle as the limit wins: normal transition, no Error.
- Error stays set until reset.
- MemListo outside memory states is ignored.
- Opcode is sampled only in DECODE and EXEC_I (ALUOp).
- Reset mid-instruction: immediate return to FETCH. No write strobe may glitch high during reset.
- Latency (zero-wait memory, MemListo=1 on the first cycle):
  - R-type, I-type, sw: 4 cycles
  - lw: 5 cycles
  - beq, j: 3 cycles

Test Plan:
- Reset release, MemListo=1 always, Opcode=000000 → Estado sequence 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7; 4 cycles per instruction.
- Opcode=100011 (lw), MemListo low 3 cycles in MEM_READ → Estado 0,1,2,3,3,3,3,4,0; MemRead=IorD=1 throughout state 3; RegWrite=MemtoReg=1 in state 4.
- Opcode=001101 (ori) then 001000 (addi) → Signo=0 from the cycle after DECODE of ori; back to 1 after DECODE of addi; ALUOp=11 for ori, 00 for addi in EXEC_I.
- MemListo held 0 in FETCH with MAX_ESPERA=15 → Error rises after 15 cycles, Estado stays 0, IRWrite never 1; then MemListo=1 → normal fetch, Error remains 1.
- Opcode=111111 → Estado 0,1,12,0; no write strobes asserted. Opcode=000010 → PCWrite=1 with PCSource=10 in state 9.
- rst_n pulsed low during MEM_WRITE → Estado=0, MemWrite=0 asynchronously, Error=0, Signo=1.
